ccr_unit: RTL

Condition-code register stage directly downstream of the ALU in the EX stage. It latches the ALU's `{V,C,N,Z}` flags on each clock edge, but only the bits that the current `alu_fun` architecturally defines. It returns the registered carry to the ALU for RLC/RRC and evaluates conditional-branch conditions. It also keeps a single-level shadow copy of the flags for interrupt entry and RTI.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/ccr_mask_decode.sv | 25 ++
 rtl/ccr_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared ALU opcodes, flag indices and branch-condition codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int ALU_FUN_W = 6;
  localparam int CCR_W     = 4;

  localparam logic [ALU_FUN_W-1:0] ALU_ADD  = 6'd2;
  localparam logic [ALU_FUN_W-1:0] ALU_SUB  = 6'd3;
  localparam logic [ALU_FUN_W-1:0] ALU_OR   = 6'd5;
  localparam logic [ALU_FUN_W-1:0] ALU_RLC  = 6'd6;
  localparam logic [ALU_FUN_W-1:0] ALU_RRC  = 6'd7;
  localparam logic [ALU_FUN_W-1:0] ALU_SETC = 6'd8;
  localparam logic [ALU_FUN_W-1:0] ALU_CLRC = 6'd9;
  localparam logic [ALU_FUN_W-1:0] ALU_NOT  = 6'd14;
  localparam logic [ALU_FUN_W-1:0] ALU_NEG  = 6'd15;
  localparam logic [ALU_FUN_W-1:0] ALU_INC  = 6'd16;
  localparam logic [ALU_FUN_W-1:0] ALU_DEC  = 6'd17;
  localparam logic [ALU_FUN_W-1:0] ALU_LOOP = 6'd22;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  localparam logic [CCR_W-1:0] MASK_ALL  = 4'b1111;
  localparam logic [CCR_W-1:0] MASK_ZN   = 4'b0011;
  localparam logic [CCR_W-1:0] MASK_C    = 4'b0100;
  localparam logic [CCR_W-1:0] MASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    BR_Z = 2'd0,
    BR_N = 2'd1,
    BR_C = 2'd2,
    BR_V = 2'd3
  } br_cond_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ccr_mask_decode.sv
`default_nettype none
// ============================================================================
// Module      : ccr_mask_decode
// Description : Maps an ALU opcode to the set of flags it architecturally writes.
// Revision    : 1.0 - initial release
// ============================================================================
module ccr_mask_decode
  import cpu_pkg::*;
(
  input  logic [ALU_FUN_W-1:0] alu_fun,
  output logic [CCR_W-1:0]     wmask
);

  always_comb begin
    wmask = MASK_NONE;
    case (alu_fun)
      ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC:    wmask = MASK_ALL;
      ALU_OR, ALU_NOT, ALU_NEG, ALU_LOOP:    wmask = MASK_ZN;
      ALU_RLC, ALU_RRC, ALU_SETC, ALU_CLRC:  wmask = MASK_C;
      default:                               wmask = MASK_NONE;
    endcase
  end

endmodule : ccr_mask_decode
`default_nettype wire

// File: rtl/ccr_unit.sv
`default_nettype none
// ============================================================================
// Module      : ccr_unit
// Description : Masked condition-code register with branch evaluation and a
//               single-level interrupt shadow.
// Revision    : 1.0 - initial release
// ============================================================================
module ccr_unit
  import cpu_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 ex_valid,
  input  logic                 flush,
  input  logic [ALU_FUN_W-1:0] alu_fun,
  input  logic [FLAG_W-1:0]    alu_flags,
  input  logic                 int_save,
  input  logic                 rti_restore,
  input  logic                 br_req,
  input  logic [1:0]           br_cond,
  output logic [FLAG_W-1:0]    ccr,
  output logic                 carry_out,
  output logic                 br_taken,
  output logic                 shadow_valid
);

  logic [FLAG_W-1:0] r_ccr;
  logic [FLAG_W-1:0] r_shadow;
  logic              r_shadow_valid;

  logic [FLAG_W-1:0] w_wmask;
  logic              w_we;
  logic [FLAG_W-1:0] w_wm;
  logic [FLAG_W-1:0] w_clr;
  logic [FLAG_W-1:0] w_ccr_next;
  logic              w_br_taken;
  logic              w_restore;

  ccr_mask_decode u_mask_decode (
    .alu_fun (alu_fun),
    .wmask   (w_wmask)
  );

  // Branch sees only the registered flags; no forwarding from alu_flags.
  assign w_br_taken = br_req & r_ccr[br_cond];
  assign w_we       = ex_valid & ~flush & ~stall;
  assign w_wm       = w_we ? w_wmask : '0;
  assign w_clr      = (w_br_taken & ~stall) ? (FLAG_W'(1) << br_cond) : '0;
  assign w_ccr_next = (r_ccr & ~w_clr & ~w_wm) | (alu_flags & w_wm);
  assign w_restore  = rti_restore & r_shadow_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ccr          <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
    end else if (!stall) begin
      if (w_restore) begin
        // A concurrent save reloads the shadow with the value it already holds.
        r_ccr          <= r_shadow;
        r_shadow_valid <= int_save;
      end else begin
        r_ccr <= w_ccr_next;
        if (int_save) begin
          r_shadow       <= w_ccr_next;
          r_shadow_valid <= 1'b1;
        end
      end
    end
  end

  assign ccr          = r_ccr;
  assign carry_out    = r_ccr[FLG_C];
  assign br_taken     = w_br_taken;
  assign shadow_valid = r_shadow_valid;

endmodule : ccr_unit
`default_nettype wire
